// File: rtl/ap_kernel_driver_pkg.sv
// Shared types and default widths for the ap_start/ap_done kernel driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ap_drv_pkg;

    // Driver sequencing: wait for a free kernel, hold ap_start one cycle, then wait for ap_done.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int DEF_W     = 32;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_CYC_W = 16;

endpackage

// File: rtl/ap_kernel_driver_if.sv
// Bundle of the request stream, result stream and kernel block-level handshake.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carried here; master = driver, slave = environment + kernel.
interface ap_kernel_driver_if
    import ap_drv_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int TAG_W = DEF_TAG_W,
    parameter int CYC_W = DEF_CYC_W
) ();
    // request stream
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_n;
    // result stream
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [CYC_W-1:0] out_cycles;
    // kernel ap_* handshake
    logic             k_start;
    logic [W-1:0]     k_n;
    logic             k_done;
    logic             k_idle;
    logic             k_ready;
    logic [W-1:0]     k_return;

    modport master (
        input  in_valid, in_n, out_ready, k_done, k_idle, k_ready, k_return,
        output in_ready, out_valid, out_data, out_tag, out_cycles, k_start, k_n
    );

    modport slave (
        output in_valid, in_n, out_ready, k_done, k_idle, k_ready, k_return,
        input  in_ready, out_valid, out_data, out_tag, out_cycles, k_start, k_n
    );
endinterface

// File: rtl/ap_kernel_driver_req_fifo.sv
// Generic synchronous FIFO with registered count; holds pending kernel arguments.
// Latency: a push is visible at head_o on the next cycle.
// Backpressure: full_o from the registered count; push while full is taken only with a same-cycle pop.
// Ports: ap_clk/ap_rst_n, push_i/push_dat_i write side, pop_i/head_o read side, full_o/empty_o status.
module req_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/ap_kernel_driver.sv
// Feeds queued arguments to an ap_ctrl_hs kernel one job at a time; returns result + tag + latency.
// Latency: earliest k_start 2 cycles after accept; out_valid the edge after the first WAIT cycle with k_done.
// Backpressure: in_ready low when the FIFO is full; a held result blocks the next issue until it is taken.
// Ports: ap_clk, ap_rst_n (async active-low), bus = request/result streams and kernel ap_* signals.
module ap_kernel_driver
    import ap_drv_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = 4,
    parameter int TAG_W = DEF_TAG_W,
    parameter int CYC_W = DEF_CYC_W
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    ap_kernel_driver_if.master bus
);
    state_e           state_q;
    logic             k_start_q;
    logic [W-1:0]     k_n_q;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [CYC_W-1:0] out_cycles_q;
    logic [TAG_W-1:0] seq_q;
    logic [CYC_W-1:0] cnt_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [W-1:0]     fifo_head;
    logic             push;
    logic             slot_free;
    logic             issue;

    assign push      = bus.in_valid && !fifo_full;
    // The slot counts as free when the consumer takes the held result this very cycle.
    assign slot_free = !out_valid_q || bus.out_ready;
    // Requiring k_idle also covers a kernel still finishing a job orphaned by our reset:
    // nothing issues until it reports idle, and we never reset the kernel ourselves.
    assign issue     = (state_q == ST_IDLE) && !fifo_empty && bus.k_idle && bus.k_ready && slot_free;

    req_fifo #(.W(W), .DEPTH(DEPTH)) u_req_fifo (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .push_i     (push),
        .push_dat_i (bus.in_n),
        .pop_i      (issue),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            k_start_q    <= 1'b0;
            k_n_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_cycles_q <= '0;
            seq_q        <= '0;
            cnt_q        <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        k_n_q     <= fifo_head;
                        k_start_q <= 1'b1;
                        cnt_q     <= CYC_W'(1);
                        state_q   <= ST_START;
                    end
                end
                // k_done here may be left over from the previous job, so it is not looked at.
                ST_START: begin
                    k_start_q <= 1'b0;
                    state_q   <= ST_WAIT;
                end
                // The output slot is guaranteed empty here: issue only happens once it is free.
                ST_WAIT: begin
                    if (bus.k_done) begin
                        out_data_q   <= bus.k_return;
                        out_tag_q    <= seq_q;
                        out_cycles_q <= cnt_q;
                        out_valid_q  <= 1'b1;
                        seq_q        <= seq_q + TAG_W'(1);
                        state_q      <= ST_IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CYC_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_cycles = out_cycles_q;
    assign bus.k_start    = k_start_q;
    assign bus.k_n        = k_n_q;
endmodule

// File: tb/tb_ap_kernel_driver.sv
// Randomized scoreboard bench for ap_kernel_driver with a behavioural Fibonacci kernel.
// Latency: n/a.
// Backpressure: out_ready is driven directly or randomly per test phase.
module tb_ap_kernel_driver;
    import ap_drv_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CYC_W = 16;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    ap_kernel_driver_if #(.W(W), .TAG_W(TAG_W), .CYC_W(CYC_W)) bus ();

    ap_kernel_driver #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .CYC_W(CYC_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: Fibonacci value and the kernel latency rule used by the kernel model below.
    function automatic logic [W-1:0] fib(input logic [W-1:0] n);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] t;
        a = '0;
        b = 1;
        for (int i = 0; i < int'(n) && i < 64; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int lat(input logic [W-1:0] n);
        return (n < 2) ? 2 : int'(n) + 1;
    endfunction

    // ---------------- behavioural kernel (never reset by the driver) ----------------
    logic         kb_busy    = 1'b0;
    int           kb_rem     = 0;
    logic         kb_done_q  = 1'b0;
    logic [W-1:0] kb_n       = '0;
    logic         stale_mode = 1'b0;

    always @(posedge ap_clk) begin
        if (bus.k_start && !kb_busy) begin
            kb_busy   <= 1'b1;
            kb_rem    <= lat(bus.k_n);
            kb_n      <= bus.k_n;
            kb_done_q <= 1'b0;
        end else if (kb_busy) begin
            if (kb_rem == 0) begin
                kb_busy   <= 1'b0;
                kb_done_q <= 1'b1;
            end else begin
                kb_rem <= kb_rem - 1;
            end
        end
    end

    // In stale mode ap_done stays high after a job until the next ap_start is sampled.
    assign bus.k_done   = (kb_busy && kb_rem == 0) || (stale_mode && kb_done_q);
    assign bus.k_idle   = !kb_busy;
    assign bus.k_ready  = !kb_busy;
    assign bus.k_return = fib(kb_n);

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [W-1:0]     n;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             exp_q[$];
    logic [TAG_W-1:0] seq_m = '0;
    int               results = 0;
    logic [W-1:0]     last_data = '0;
    logic [TAG_W-1:0] last_tag = '0;
    int               kstart_cnt = 0;
    logic             rdy_rand = 1'b0;

    // Result monitor: compares each handed-over result and checks stability while stalled.
    initial begin
        logic             hold;
        logic [W-1:0]     p_data;
        logic [TAG_W-1:0] p_tag;
        logic [CYC_W-1:0] p_cyc;
        exp_t             e;
        hold = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                hold = 1'b0;
            end else if (bus.out_valid) begin
                if (hold) begin
                    chk("hold_data", bus.out_data, p_data);
                    chk("hold_tag", bus.out_tag, p_tag);
                    chk("hold_cycles", bus.out_cycles, p_cyc);
                end
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", bus.out_data, fib(e.n));
                        chk("res_tag", bus.out_tag, e.tag);
                        chk("res_cycles", bus.out_cycles, lat(e.n) + 1);
                    end
                    last_data = bus.out_data;
                    last_tag  = bus.out_tag;
                    results++;
                    hold = 1'b0;
                end else begin
                    hold   = 1'b1;
                    p_data = bus.out_data;
                    p_tag  = bus.out_tag;
                    p_cyc  = bus.out_cycles;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    // k_start monitor: single-cycle pulses, only towards an idle kernel.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n && bus.k_start) begin
                chk("kstart_to_idle", bus.k_idle, 1);
                chk("kstart_single_cycle", prev, 0);
                kstart_cnt++;
            end
            prev = ap_rst_n && bus.k_start;
        end
    end

    // Random consumer back-pressure.
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        seq_m = '0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_out_cycles", bus.out_cycles, 0);
        chk("rst_k_start", bus.k_start, 0);
        chk("rst_k_n", bus.k_n, 0);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_req(input logic [W-1:0] n);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.in_n     = n;
        while (!bus.in_ready && g < 2000) begin
            @(posedge ap_clk);
            #1;
            g++;
        end
        if (!bus.in_ready) begin
            chk("push_timeout", 0, 1);
        end else begin
            exp_q.push_back('{n: n, tag: seq_m});
            seq_m = seq_m + 1'b1;
            @(posedge ap_clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            @(posedge ap_clk);
            #1;
            g++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (3) @(posedge ap_clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int           ks0;
        int           r0;
        int           acc;
        int           g;
        logic [W-1:0] vals [6];

        bus.in_valid  = 1'b0;
        bus.in_n      = '0;
        bus.out_ready = 1'b0;
        do_reset();

        // Single request
        bus.out_ready = 1'b1;
        ks0 = kstart_cnt;
        push_req(10);
        drain();
        chk("single_kstarts", kstart_cnt - ks0, 1);
        chk("single_data", last_data, 55);
        chk("single_tag", last_tag, 0);

        // Edge arguments back to back
        do_reset();
        push_req(0);
        push_req(1);
        push_req(2);
        drain();
        chk("edge_last_tag", last_tag, 2);

        // Back-pressure: consumer stalled, six requests offered
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) vals[i] = $urandom_range(0, 8);
        ks0 = kstart_cnt;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            if (acc < 6) begin
                bus.in_valid = 1'b1;
                bus.in_n     = vals[acc];
                if (bus.in_ready) begin
                    exp_q.push_back('{n: vals[acc], tag: seq_m});
                    seq_m = seq_m + 1'b1;
                    acc++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge ap_clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_accepts", acc, 5);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_single_kstart", kstart_cnt - ks0, 1);
        chk("bp_result_held", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        if (acc == 5) push_req(vals[5]);
        drain();

        // Stale done during START
        stale_mode = 1'b1;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_req($urandom_range(2, 8));
        drain();
        stale_mode = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;

        // Reset mid-job, released while the kernel is still busy
        do_reset();
        bus.out_ready = 1'b1;
        push_req(20);
        g = 0;
        while (!bus.k_start && g < 100) begin
            @(posedge ap_clk);
            #1;
            g++;
        end
        chk("midjob_kstart_seen", bus.k_start, 1);
        repeat (4) @(posedge ap_clk);
        #1;
        do_reset();
        push_req(3);
        push_req(5);
        drain();
        chk("midjob_last_tag", last_tag, 1);

        // Tag wrap with random stimulus and random back-pressure
        do_reset();
        r0 = results;
        rdy_rand = 1'b1;
        for (int i = 0; i < 17; i++) push_req($urandom_range(0, 12));
        drain();
        rdy_rand = 1'b0;
        bus.out_ready = 1'b1;
        chk("wrap_results", results - r0, 17);
        chk("wrap_tag", last_tag, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
